// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - command encodings, mode-register fields and init states for sdram_responder
package sdram_pkg;

   // {ras_n, cas_n, we_n} while cs_n is low and CKE is high
   localparam logic [2:0] CMD_NOP   = 3'b111;
   localparam logic [2:0] CMD_ACT   = 3'b011;
   localparam logic [2:0] CMD_READ  = 3'b101;
   localparam logic [2:0] CMD_WRITE = 3'b100;
   localparam logic [2:0] CMD_PRE   = 3'b010;
   localparam logic [2:0] CMD_REF   = 3'b001;
   localparam logic [2:0] CMD_MRS   = 3'b000;

   // Mode-register field positions on the address pins
   localparam int MR_CL_LSB = 4;
   localparam int MR_CL_MSB = 6;
   localparam int MR_BL_LSB = 0;
   localparam int MR_BL_MSB = 2;

   // A10 selects precharge-all / auto-precharge
   localparam int AP_BIT = 10;

   // Power-up initialisation sequencer states
   typedef logic [2:0] init_state_t;
   localparam init_state_t INIT_WAIT_PALL = 3'd0;
   localparam init_state_t INIT_WAIT_REF1 = 3'd1;
   localparam init_state_t INIT_WAIT_REF2 = 3'd2;
   localparam init_state_t INIT_WAIT_MRS  = 3'd3;
   localparam init_state_t INIT_READY     = 3'd4;

   // Collapse the pins into one command; deselect or CKE low reads as NOP
   function automatic logic [2:0] decode_cmd(input logic cke, input logic cs_n,
                                              input logic ras_n, input logic cas_n,
                                              input logic we_n);
      if (!cke || cs_n)
         return CMD_NOP;
      return {ras_n, cas_n, we_n};
   endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - SDRAM command/data pins between host (master) and responder (slave)
interface sdram_responder_if #(
   parameter int BANK_WIDTH    = 2,
   parameter int SDRADDR_WIDTH = 13
);
   logic                     clock_enable;
   logic                     cs_n;
   logic                     ras_n;
   logic                     cas_n;
   logic                     we_n;
   logic [BANK_WIDTH-1:0]    bank_addr;
   logic [SDRADDR_WIDTH-1:0] addr;
   logic                     data_mask;
   logic [7:0]               dq_in;
   logic [7:0]               dq_out;
   logic                     dq_oe;
   logic                     init_done;
   logic                     cmd_error;
   logic [15:0]              refresh_cnt;

   modport master (
      output clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr, data_mask, dq_in,
      input  dq_out, dq_oe, init_done, cmd_error, refresh_cnt
   );

   modport slave (
      input  clock_enable, cs_n, ras_n, cas_n, we_n, bank_addr, addr, data_mask, dq_in,
      output dq_out, dq_oe, init_done, cmd_error, refresh_cnt
   );
endinterface

// File: rtl/sdram_rd_pipe.sv
// rtl/sdram_rd_pipe.sv - CAS-latency delay line of {valid, data}, tap chosen by CL (2 or 3)
module sdram_rd_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cl3,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic [7:0] dq_out,
   output logic       dq_oe
);
   logic [2:0] vld;
   logic [7:0] dat0;
   logic [7:0] dat1;
   logic [7:0] dat2;

   // Shift read slots one stage per clock; reset discards anything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 3'b000;
         dat0 <= 8'h00;
         dat1 <= 8'h00;
         dat2 <= 8'h00;
      end else begin
         vld  <= {vld[1:0], in_valid};
         dat0 <= in_data;
         dat1 <= dat0;
         dat2 <= dat1;
      end
   end

   // Stage k holds a READ taken k edges ago, so CL=n taps stage n-1
   always_comb begin
      dq_oe  = 1'b0;
      dq_out = 8'h00;
      if (cl3) begin
         dq_oe  = vld[2];
         dq_out = vld[2] ? dat2 : 8'h00;
      end else begin
         dq_oe  = vld[1];
         dq_out = vld[1] ? dat1 : 8'h00;
      end
   end
endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM device model over an on-chip array; SDRAM_RESP_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int ROW_WIDTH      = 13,
   parameter int COL_WIDTH      = 10,
   parameter int BANK_WIDTH     = 2,
   parameter int SDRADDR_WIDTH  = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int T_RCD          = 2,
   parameter int T_RP           = 1,
   parameter int T_RFC          = 7
) (
   input  logic               clk,
   input  logic               rst_n,
   sdram_responder_if.slave   bus
);
   localparam int NBANK     = 1 << BANK_WIDTH;
   localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

   logic [2:0]               cmd;
   logic [BANK_WIDTH-1:0]    bank;
   logic [SDRADDR_WIDTH-1:0] a;
   logic                     auto_pre;
   logic [2:0]               mr_cl;
   logic                     cl_legal;
   logic                     bl_bad;

   logic [NBANK-1:0]         bank_open;
   logic [ROW_WIDTH-1:0]     open_row [NBANK];
   logic                     all_idle;
   logic                     sel_open;
   logic [ROW_WIDTH-1:0]     sel_row;
   logic [MEM_ADDR_WIDTH-1:0] mem_idx;
   logic [7:0]               mem [MEM_DEPTH];

   init_state_t              init_state;
   logic                     ready;
   logic [2:0]               cas_lat;
   logic                     cmd_error;
   logic [15:0]              refresh_cnt;

   logic                     state_err;
   logic                     timing_err;
   logic                     act_ok;
   logic                     rw_ok;
   logic                     ref_ok;
   logic                     mrs_ok;

   logic                     rd_valid;
   logic [7:0]               rd_data;
   logic [7:0]               pipe_dq;
   logic                     pipe_oe;

   assign cmd      = decode_cmd(bus.clock_enable, bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n);
   assign bank     = bus.bank_addr;
   assign a        = bus.addr;
   assign auto_pre = a[AP_BIT];
   assign mr_cl    = a[MR_CL_MSB:MR_CL_LSB];
   assign cl_legal = (mr_cl == 3'd2) || (mr_cl == 3'd3);
   assign bl_bad   = (a[MR_BL_MSB:MR_BL_LSB] != 3'b000);

   assign all_idle = ~|bank_open;
   assign sel_open = bank_open[bank];
   assign sel_row  = open_row[bank];
   assign ready    = (init_state == INIT_READY);
   // Linear index keeps only the low bits; higher row/bank bits alias
   assign mem_idx  = MEM_ADDR_WIDTH'({bank, sel_row, a[COL_WIDTH-1:0]});

   // Judge each command against bank state and init progress
   always_comb begin
      state_err = 1'b0;
      act_ok    = 1'b0;
      rw_ok     = 1'b0;
      ref_ok    = 1'b0;
      mrs_ok    = 1'b0;
      case (cmd)
         CMD_ACT: begin
            if (!ready || sel_open) state_err = 1'b1;
            else                    act_ok    = 1'b1;
         end
         CMD_READ, CMD_WRITE: begin
            if (!ready || !sel_open) state_err = 1'b1;
            else                     rw_ok     = 1'b1;
         end
         CMD_REF: begin
            if (!all_idle) state_err = 1'b1;
            else           ref_ok    = 1'b1;
         end
         CMD_MRS: begin
            if (!all_idle) begin
               state_err = 1'b1;
            end else begin
               mrs_ok = 1'b1;
               if (!cl_legal || bl_bad) state_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Open/close banks and remember the row each open bank holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_open <= '0;
         for (int i = 0; i < NBANK; i++) open_row[i] <= '0;
      end else begin
         case (cmd)
            CMD_ACT: begin
               if (act_ok) begin
                  bank_open[bank] <= 1'b1;
                  open_row[bank]  <= a[ROW_WIDTH-1:0];
               end
            end
            CMD_READ, CMD_WRITE: begin
               if (rw_ok && auto_pre) bank_open[bank] <= 1'b0;
            end
            CMD_PRE: begin
               if (auto_pre) bank_open       <= '0;
               else          bank_open[bank] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Backing array; contents survive reset like real DRAM cells
   always_ff @(posedge clk) begin
      if (cmd == CMD_WRITE && rw_ok && !bus.data_mask)
         mem[mem_idx] <= bus.dq_in;
   end

   // Init sequencer, CAS latency, refresh counter and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_state  <= INIT_WAIT_PALL;
         cas_lat     <= 3'd3;
         cmd_error   <= 1'b0;
         refresh_cnt <= 16'd0;
      end else begin
         if (state_err || timing_err) cmd_error <= 1'b1;
         if (ref_ok) refresh_cnt <= refresh_cnt + 16'd1;
         if (mrs_ok && cl_legal) cas_lat <= mr_cl;
         case (init_state)
            INIT_WAIT_PALL: if (cmd == CMD_PRE && auto_pre) init_state <= INIT_WAIT_REF1;
            INIT_WAIT_REF1: if (ref_ok) init_state <= INIT_WAIT_REF2;
            INIT_WAIT_REF2: if (ref_ok) init_state <= INIT_WAIT_MRS;
            INIT_WAIT_MRS:  if (mrs_ok && cl_legal && !bl_bad) init_state <= INIT_READY;
            default: ;
         endcase
      end
   end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam int TMAX = (T_RFC > T_RCD) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                                         : ((T_RCD > T_RP) ? T_RCD : T_RP);
   localparam int TCW  = $clog2(TMAX + 1);

   logic [TCW-1:0] rcd_cnt [NBANK];
   logic [TCW-1:0] rp_cnt  [NBANK];
   logic [TCW-1:0] rfc_cnt;

   // A non-zero counter means the minimum spacing has not yet elapsed
   always_comb begin
      timing_err = 1'b0;
      if (cmd != CMD_NOP && rfc_cnt != '0) timing_err = 1'b1;
      if ((cmd == CMD_READ || cmd == CMD_WRITE) && rcd_cnt[bank] != '0) timing_err = 1'b1;
      if (cmd == CMD_ACT && rp_cnt[bank] != '0) timing_err = 1'b1;
   end

   // Load counters on ACT/close/REF and count them down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfc_cnt <= '0;
         for (int i = 0; i < NBANK; i++) begin
            rcd_cnt[i] <= '0;
            rp_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NBANK; i++) begin
            if (rcd_cnt[i] != '0) rcd_cnt[i] <= rcd_cnt[i] - 1'b1;
            if (rp_cnt[i]  != '0) rp_cnt[i]  <= rp_cnt[i]  - 1'b1;
            if (cmd == CMD_PRE && (auto_pre || bank == BANK_WIDTH'(i)))
               rp_cnt[i] <= TCW'(T_RP - 1);
         end
         if (act_ok) rcd_cnt[bank] <= TCW'(T_RCD - 1);
         if (rw_ok && auto_pre) rp_cnt[bank] <= TCW'(T_RP - 1);
         if (ref_ok)                 rfc_cnt <= TCW'(T_RFC - 1);
         else if (rfc_cnt != '0)     rfc_cnt <= rfc_cnt - 1'b1;
      end
   end
`else
   assign timing_err = 1'b0;
`endif

   assign rd_valid = (cmd == CMD_READ) && rw_ok && !bus.data_mask;
   assign rd_data  = mem[mem_idx];

   sdram_rd_pipe u_rd_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .cl3      (cas_lat == 3'd3),
      .in_valid (rd_valid),
      .in_data  (rd_data),
      .dq_out   (pipe_dq),
      .dq_oe    (pipe_oe)
   );

   assign bus.dq_out      = pipe_dq;
   assign bus.dq_oe       = pipe_oe;
   assign bus.init_done   = ready;
   assign bus.cmd_error   = cmd_error;
   assign bus.refresh_cnt = refresh_cnt;
endmodule

// File: tb/tb_sdram_responder.sv
// tb/tb_sdram_responder.sv - directed bench with read-data scoreboard for sdram_responder
module tb_sdram_responder;
   import sdram_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   sdram_responder_if #(.BANK_WIDTH(2), .SDRADDR_WIDTH(13)) bus ();

   sdram_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam logic TIMING_EN = 1'b1;
`else
   localparam logic TIMING_EN = 1'b0;
`endif

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;

   exp_t        sbq[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          cl_m     = 3;
   logic [12:0] row_m [4];
   logic [7:0]  mem_m [int];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int mk_idx(input logic [1:0] b, input logic [9:0] col);
      logic [24:0] f;
      f = {b, row_m[b], col};
      return int'(f[11:0]);
   endfunction

   // One command edge; afterwards the read bus must match the scoreboard head
   task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [7:0] d, input logic m);
      exp_t e;
      bus.clock_enable = 1'b1;
      bus.cs_n         = (c == CMD_NOP);
      {bus.ras_n, bus.cas_n, bus.we_n} = c;
      bus.bank_addr    = b;
      bus.addr         = a;
      bus.dq_in        = d;
      bus.data_mask    = m;
      @(posedge clk);
      cyc++;
      #1;
      if (sbq.size() != 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         check("rd_oe", {15'd0, bus.dq_oe}, 16'd1);
         check("rd_data", {8'd0, bus.dq_out}, {8'd0, e.data});
      end else begin
         check("oe_idle", {15'd0, bus.dq_oe}, 16'd0);
      end
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(CMD_NOP, 2'd0, 13'd0, 8'd0, 1'b0);
   endtask

   task automatic act(input logic [1:0] b, input logic [12:0] row);
      row_m[b] = row;
      step(CMD_ACT, b, row, 8'd0, 1'b0);
   endtask

   task automatic wr(input logic [1:0] b, input logic [9:0] col, input logic [7:0] d,
                     input logic ap, input logic m);
      if (!m) mem_m[mk_idx(b, col)] = d;
      step(CMD_WRITE, b, {2'b00, ap, col}, d, m);
   endtask

   task automatic rd(input logic [1:0] b, input logic [9:0] col, input logic ap,
                     input logic m, input logic ok);
      exp_t e;
      if (ok && !m) begin
         e.due  = cyc + cl_m;
         e.data = mem_m[mk_idx(b, col)];
         sbq.push_back(e);
      end
      step(CMD_READ, b, {2'b00, ap, col}, 8'd0, m);
   endtask

   task automatic mrs(input logic [12:0] a);
      step(CMD_MRS, 2'd0, a, 8'd0, 1'b0);
      if (a[6:4] == 3'd2 || a[6:4] == 3'd3) cl_m = int'(a[6:4]);
   endtask

   task automatic init_seq();
      step(CMD_PRE, 2'd0, 13'h400, 8'd0, 1'b0);
      nop(2);
      step(CMD_REF, 2'd0, 13'd0, 8'd0, 1'b0);
      nop(8);
      step(CMD_REF, 2'd0, 13'd0, 8'd0, 1'b0);
      nop(8);
      mrs(13'h230);
      nop(2);
   endtask

   task automatic check_reset_values();
      check("rst_dq_out", {8'd0, bus.dq_out}, 16'd0);
      check("rst_dq_oe", {15'd0, bus.dq_oe}, 16'd0);
      check("rst_init_done", {15'd0, bus.init_done}, 16'd0);
      check("rst_cmd_error", {15'd0, bus.cmd_error}, 16'd0);
      check("rst_refresh_cnt", bus.refresh_cnt, 16'd0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.clock_enable = 1'b1;
      bus.cs_n         = 1'b1;
      bus.ras_n        = 1'b1;
      bus.cas_n        = 1'b1;
      bus.we_n         = 1'b1;
      bus.bank_addr    = 2'd0;
      bus.addr         = 13'd0;
      bus.data_mask    = 1'b0;
      bus.dq_in        = 8'd0;
      for (int i = 0; i < 4; i++) row_m[i] = 13'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values();
      rst_n = 1'b1;

      // NOPs only: nothing initialises, no error, no drive
      nop(5);
      check("nop_init_done", {15'd0, bus.init_done}, 16'd0);
      check("nop_cmd_error", {15'd0, bus.cmd_error}, 16'd0);

      // Init sequence, CL=3
      init_seq();
      check("init_done", {15'd0, bus.init_done}, 16'd1);
      check("init_refresh_cnt", bus.refresh_cnt, 16'd2);
      check("init_cmd_error", {15'd0, bus.cmd_error}, 16'd0);

      // Write with auto-precharge, reopen, read back at CL=3
      act(2'd1, 13'h0055);
      nop(2);
      wr(2'd1, 10'h012, 8'hA5, 1'b1, 1'b0);
      act(2'd1, 13'h0055);
      nop(2);
      rd(2'd1, 10'h012, 1'b0, 1'b0, 1'b1);
      nop(4);

      // Write then read next cycle; masked write; masked read
      wr(2'd1, 10'h020, 8'h5C, 1'b0, 1'b0);
      rd(2'd1, 10'h020, 1'b0, 1'b0, 1'b1);
      wr(2'd1, 10'h030, 8'h66, 1'b0, 1'b0);
      wr(2'd1, 10'h030, 8'h77, 1'b0, 1'b1);
      rd(2'd1, 10'h030, 1'b0, 1'b0, 1'b1);
      rd(2'd1, 10'h030, 1'b0, 1'b1, 1'b1);
      nop(5);
      check("rw_cmd_error", {15'd0, bus.cmd_error}, 16'd0);

      // CL=2 and four back-to-back reads
      step(CMD_PRE, 2'd0, 13'h400, 8'd0, 1'b0);
      nop(2);
      mrs(13'h220);
      nop(1);
      act(2'd0, 13'h0000);
      nop(2);
      wr(2'd0, 10'h000, 8'h11, 1'b0, 1'b0);
      wr(2'd0, 10'h001, 8'h22, 1'b0, 1'b0);
      wr(2'd0, 10'h002, 8'h33, 1'b0, 1'b0);
      wr(2'd0, 10'h003, 8'h44, 1'b0, 1'b0);
      rd(2'd0, 10'h000, 1'b0, 1'b0, 1'b1);
      rd(2'd0, 10'h001, 1'b0, 1'b0, 1'b1);
      rd(2'd0, 10'h002, 1'b0, 1'b0, 1'b1);
      rd(2'd0, 10'h003, 1'b0, 1'b0, 1'b1);
      nop(3);

      // Read with auto-precharge, ACT on the very next edge is legal
      rd(2'd0, 10'h001, 1'b1, 1'b0, 1'b1);
      act(2'd0, 13'h0000);
      nop(3);
      check("ap_cmd_error", {15'd0, bus.cmd_error}, 16'd0);
      check("sb_drained", 16'(sbq.size()), 16'd0);

      // Protocol errors: READ to idle bank, REF with a bank open
      rd(2'd2, 10'h005, 1'b0, 1'b0, 1'b0);
      nop(3);
      check("rd_idle_err", {15'd0, bus.cmd_error}, 16'd1);
      step(CMD_REF, 2'd0, 13'd0, 8'd0, 1'b0);
      nop(1);
      check("ref_open_cnt", bus.refresh_cnt, 16'd2);
      check("ref_open_err", {15'd0, bus.cmd_error}, 16'd1);

      // Reset while a read is in flight kills the data slot
      rd(2'd0, 10'h000, 1'b0, 1'b0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrd_dq_oe", {15'd0, bus.dq_oe}, 16'd0);
      sbq.delete();
      cl_m = 3;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         check("rst_hold_oe", {15'd0, bus.dq_oe}, 16'd0);
      end
      check_reset_values();
      rst_n = 1'b1;

      // READ one cycle after ACT: error only when timing checks are built
      init_seq();
      act(2'd2, 13'h0003);
      nop(2);
      wr(2'd2, 10'h005, 8'h9E, 1'b0, 1'b0);
      step(CMD_PRE, 2'd2, 13'h000, 8'd0, 1'b0);
      nop(1);
      check("tm_pre_err", {15'd0, bus.cmd_error}, 16'd0);
      act(2'd2, 13'h0003);
      rd(2'd2, 10'h005, 1'b0, 1'b0, 1'b1);
      nop(4);
      check("tm_rcd_err", {15'd0, bus.cmd_error}, {15'd0, TIMING_EN});
      check("tm_sb_drained", 16'(sbq.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synthesizable single-chip SDRAM device responder: the far end of the host SDRAM command bus, used as the memory in controller benches and in FPGA loopback builds with no external SDRAM. It decodes CKE/CS/RAS/CAS/WE commands, tracks per-bank row state, holds the mode register, and returns read data after the programmed CAS latency. It backs a small on-chip array and flags protocol misuse on a sticky error output.

## Interface
- ROW_WIDTH, 13, row address bits
- COL_WIDTH, 10, column address bits
- BANK_WIDTH, 2, bank address bits
- SDRADDR_WIDTH, max(ROW_WIDTH, COL_WIDTH), address pin width
- MEM_ADDR_WIDTH, 12, log2 of backing array depth (bytes)
- T_RCD, 2, min cycles ACT→READ/WRITE (checked only with macro)
- T_RP, 1, min cycles PRECHARGE→ACT same bank (macro)
- T_RFC, 7, min cycles REF→next non-NOP command (macro)

Ports:
- clk  in  1  command clock; all pins sampled on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- clock_enable  in  1  CKE; low = command ignored (treated as NOP)
- cs_n, ras_n, cas_n, we_n  in  1 each  command pins
- bank_addr  in  BANK_WIDTH  bank select
- addr  in  SDRADDR_WIDTH  row / column / mode; addr[10] = precharge-all or auto-precharge
- data_mask  in  1  DQM; high blocks write and read drive
- dq_in  in  8  write data from host
- dq_out  out  8  read data
- dq_oe  out  1  drive enable for dq_out
- init_done  out  1  PALL + two REF + MRS seen in order
- cmd_error  out  1  sticky protocol-violation flag
- refresh_cnt  out  16  count of accepted REF commands, wraps

## Operation
- Commands (cs_n low, CKE high), {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRECHARGE, 001 REF, 000 MRS. cs_n high = NOP.
- Init sequencer: WAIT_PALL → WAIT_REF1 → WAIT_REF2 → WAIT_MRS → READY. Before READY, ACT/READ/WRITE set cmd_error and are otherwise ignored. init_done = (state == READY).
- MRS: all banks must be idle, else cmd_error and no update. Latches CL = addr[6:4] (only 2 or 3 legal; others → cmd_error, CL unchanged) and BL = addr[2:0] (must be 000; others → cmd_error).
- ACT: bank must be idle, else cmd_error. Records open row = addr[ROW_WIDTH-1:0].
- READ/WRITE: bank must be active, else cmd_error, no access. Array index = low MEM_ADDR_WIDTH bits of {bank, open_row, addr[COL_WIDTH-1:0]}; aliasing permitted. addr[10]=1 closes the bank after the access.
- WRITE stores dq_in on the command edge unless data_mask is high.
- PRECHARGE: addr[10]=1 closes all banks, else the addressed bank. Closing an idle bank is legal.
- REF: all banks idle, else cmd_error and not counted.
- cmd_error clears only on reset.

## Timing
- Reset (async): dq_out=0, dq_oe=0, init_done=0, cmd_error=0, refresh_cnt=0, all banks idle, CL=3, BL=1, init in WAIT_PALL. Reset mid-read kills pending data; dq_oe is 0 on the next edge.
- Read latency: READ sampled at edge N → dq_out valid and dq_oe=1 for exactly the cycle after edge N+CL−1, i.e. sampled by host at edge N+CL. A READ with data_mask high gives dq_oe=0 for that slot.
- Back-to-back READs every cycle are accepted. Each produces one data slot, pipelined through the CL delay line.
- WRITE, then READ of the same index on the next cycle returns the new data.
- READ with auto-precharge: bank idle from edge N+1; ACT to it at N+1 is legal.
- Simultaneous READ data return and an incoming WRITE: the return is unaffected, and no bus-contention check is made.

## Configuration
- SDRAM_RESP_TIMING_CHECK_EN: when defined, per-bank counters enforce T_RCD and T_RP, and a global counter enforces T_RFC. A violation sets cmd_error and the command is still executed.
- When undefined, no timing counters are built. Only state-legality errors set cmd_error.

## Structure
- Shared sdram_pkg: command encoding constants (CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF, CMD_MRS), mode-register field positions, init-state enum.
- One sub-module, sdram_rd_pipe: CL-deep shift register of {valid, data}, with length selected by CL (2 or 3).

## Test plan
- Reset, then drive NOP only → init_done=0, cmd_error=0, dq_oe never 1.
- PALL, REF, REF, MRS addr=0x230 → init_done=1, CL=3, refresh_cnt=2.
- ACT bank1 row 0x0055, WRITE col 0x012 data 0xA5 with A10=1, ACT again, READ col 0x012 at edge N → dq_oe=1 and dq_out=0xA5 sampled at edge N+3 only.
- READ to idle bank 2 → cmd_error=1, dq_oe stays 0; REF with bank 0 open → cmd_error=1, refresh_cnt unchanged.
- MRS CL=2, then four back-to-back READs of pre-written 0x11/0x22/0x33/0x44 → the same values are returned on four consecutive cycles, starting at N+2.
- With SDRAM_RESP_TIMING_CHECK_EN: ACT then READ one cycle later → cmd_error=1. Without the macro, the same sequence → cmd_error=0 and the data is returned.
